or_gate_stim_checker: RTL and testbench

//  Self-running stimulus and checker stage wrapped around the combinational OR gate under test.

---
 rtl/or_gate_stim_checker.sv | 143 ++++++++++++++
 tb/tb_or_gate_stim_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/or_gate_stim_checker.sv
// Self-running stimulus/checker around a combinational OR gate under test.
// Steps the gate inputs through every combination in ascending order, holds
// each vector for SETTLE cycles, samples the gate output for one cycle and
// accumulates mismatches. A run is requested with start_i; results are held
// in DONE until the next start or reset.
module or_gate_stim_checker #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              y_in_i,
    output logic [N_IN-1:0]   a_vec_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [N_IN:0]     err_count_o,
    output logic [N_IN-1:0]   first_fail_o
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned ERR_W = N_IN + 1;
    localparam logic [N_IN-1:0]  VEC_LAST   = '1;
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [N_IN-1:0]    ff_q, ff_d;
    logic               seen_q, seen_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               mismatch_c;

    // X/Z on the gate output is treated as a mismatch, hence the case inequality
    always_comb begin
        mismatch_c = (y_in_i !== (|vec_q));
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath updates and registered output decode
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        seen_d  = seen_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_WAIT;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    seen_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_SETTLE) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (mismatch_c) begin
                    err_d = err_q + ERR_W'(1);
                    if (!seen_q) begin
                        ff_d   = vec_q;
                        seen_d = 1'b1;
                    end
                end
                // Compare before incrementing so vec never wraps
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_d == '0);
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vec_q  <= '0;
            cnt_q  <= '0;
            err_q  <= '0;
            ff_q   <= '0;
            seen_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            ff_q   <= ff_d;
            seen_q <= seen_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign a_vec_o      = vec_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_count_o  = err_q;
    assign first_fail_o = ff_q;

endmodule

// File: tb/tb_or_gate_stim_checker.sv
// Directed bench for or_gate_stim_checker: SETTLE=2 and SETTLE=1 instances,
// with a behavioural gate that can be correct, stuck at 0, or an AND gate.
module tb_or_gate_stim_checker;

    logic clk;
    logic rst;
    logic start_a, start_b;
    logic y_a, y_b;
    logic [1:0] av_a, av_b, ff_a, ff_b;
    logic [2:0] ec_a, ec_b;
    logic bz_a, bz_b, dn_a, dn_b, ps_a, ps_b;

    int mode;   // 0: OR gate, 1: stuck at 0, 2: AND gate
    int sel;    // 0: SETTLE=2 instance, 1: SETTLE=1 instance
    int n_tests;
    int n_fail;

    logic [1:0] av, ff;
    logic [2:0] ec;
    logic bz, dn, ps;

    or_gate_stim_checker #(.N_IN(2), .SETTLE(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .y_in_i(y_a),
        .a_vec_o(av_a), .busy_o(bz_a), .done_o(dn_a), .pass_o(ps_a),
        .err_count_o(ec_a), .first_fail_o(ff_a)
    );

    or_gate_stim_checker #(.N_IN(2), .SETTLE(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .y_in_i(y_b),
        .a_vec_o(av_b), .busy_o(bz_b), .done_o(dn_b), .pass_o(ps_b),
        .err_count_o(ec_b), .first_fail_o(ff_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate models
    always_comb begin
        case (mode)
            1:       begin y_a = 1'b0;    y_b = 1'b0;    end
            2:       begin y_a = &av_a;   y_b = &av_b;   end
            default: begin y_a = |av_a;   y_b = |av_b;   end
        endcase
    end

    // Observed-signal select
    always_comb begin
        if (sel == 0) begin
            av = av_a; ff = ff_a; ec = ec_a; bz = bz_a; dn = dn_a; ps = ps_a;
        end else begin
            av = av_b; ff = ff_b; ec = ec_b; bz = bz_b; dn = dn_b; ps = ps_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then trace the run edge by edge until DONE.
    // per = SETTLE+1; restart_at > 0 raises start again so it is sampled at that edge.
    task automatic run(input int s, input int per, input int restart_at, output int edges);
        int exp_v;
        sel = s;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        edges = -1;
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) tick();
            if (restart_at > 0 && k == restart_at) set_start(1'b0);
            if (dn === 1'b1) begin
                edges = k;
                break;
            end
            exp_v = k / per;
            if (exp_v > 3) exp_v = 3;
            check($sformatf("a_vec_k%0d", k), 32'(av), 32'(exp_v));
            check($sformatf("busy_k%0d", k), 32'(bz), 32'd1);
            if (restart_at > 0 && k == restart_at - 1) set_start(1'b1);
        end
        if (edges < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_results(input string tag, input int e_edges, input int got_edges,
                                 input int e_err, input int e_ff, input int e_pass);
        check({tag, "_edges"}, 32'(got_edges), 32'(e_edges));
        check({tag, "_done"},  32'(dn), 32'd1);
        check({tag, "_busy"},  32'(bz), 32'd0);
        check({tag, "_err"},   32'(ec), 32'(e_err));
        check({tag, "_ff"},    32'(ff), 32'(e_ff));
        check({tag, "_pass"},  32'(ps), 32'(e_pass));
        check({tag, "_avec"},  32'(av), 32'd3);
    endtask

    int edges;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mode    = 0;
        sel     = 0;
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_avec", 32'(av_a), 32'd0);
        check("rst_busy", 32'(bz_a), 32'd0);
        check("rst_done", 32'(dn_a), 32'd0);
        check("rst_pass", 32'(ps_a), 32'd0);
        check("rst_err",  32'(ec_a), 32'd0);
        check("rst_ff",   32'(ff_a), 32'd0);
        check("rst_b_done", 32'(dn_b), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(bz_a), 32'd0);

        // 1: correct gate
        mode = 0;
        run(0, 3, 0, edges);
        check_results("s1", 12, edges, 0, 0, 1);
        repeat (3) tick();
        check("s1_hold_done", 32'(dn), 32'd1);
        check("s1_hold_pass", 32'(ps), 32'd1);

        // 2: output stuck at 0
        mode = 1;
        run(0, 3, 0, edges);
        check_results("s2", 12, edges, 3, 1, 0);
        tick();

        // 3: wrong gate (AND)
        mode = 2;
        run(0, 3, 0, edges);
        check_results("s3", 12, edges, 2, 1, 0);
        tick();

        // 4: start re-pulsed mid-run is ignored
        mode = 0;
        run(0, 3, 5, edges);
        check_results("s4", 12, edges, 0, 0, 1);
        tick();

        // 5: reset at edge 7 of a run
        sel = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (6) tick();
        check("s5_busy_pre", 32'(bz_a), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_rst_avec", 32'(av_a), 32'd0);
        check("s5_rst_err",  32'(ec_a), 32'd0);
        check("s5_rst_busy", 32'(bz_a), 32'd0);
        check("s5_rst_done", 32'(dn_a), 32'd0);
        tick();
        check("s5_idle_busy", 32'(bz_a), 32'd0);
        run(0, 3, 0, edges);
        check_results("s5", 12, edges, 0, 0, 1);
        tick();

        // 6: rerun from DONE with errors, counters clear at the start edge
        mode = 1;
        run(0, 3, 0, edges);
        check_results("s6a", 12, edges, 3, 1, 0);
        mode = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("s6_clr_err",  32'(ec_a), 32'd0);
        check("s6_clr_ff",   32'(ff_a), 32'd0);
        check("s6_clr_done", 32'(dn_a), 32'd0);
        check("s6_clr_busy", 32'(bz_a), 32'd1);
        edges = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (dn_a === 1'b1) begin
                edges = k;
                break;
            end
        end
        check_results("s6b", 12, edges, 0, 0, 1);

        // 6b: SETTLE=1 instance, dirty then clean run
        mode = 1;
        run(1, 2, 0, edges);
        check_results("s6c", 8, edges, 3, 1, 0);
        mode = 0;
        run(1, 2, 0, edges);
        check_results("s6d", 8, edges, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
